mult_div_unit: RTL

Sequential 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. It accepts MULT/MULTU/DIV/DIVU from the ALU-stage decode, iterates one bit per cycle and holds the 64-bit result in HI/LO. The hi/lo outputs feed the write-back 4-to-1 result select (MFHI/MFLO channels). busy feeds the hazard logic, which stalls dependent MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Sequential 32-bit multiply/divide unit with architectural HI/LO registers
// for the MIPS execute stage. One iteration per clock: shift-add for
// MULT/MULTU, restoring shift-subtract for DIV/DIVU. Signed operations run
// on magnitudes and the signs are applied in a final FIX cycle.
// Start-to-result latency is 33 cycles.
//
// Build option:
//   MULT_DIV_UNIT_DIVIDER_EN  defined   -> MULT/MULTU/DIV/DIVU supported
//                             undefined -> divide datapath is not built; a
//                                          DIV/DIVU start pulses done on the
//                                          next cycle and leaves HI/LO as-is
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start, op      launch request (accepted only while idle);
//                  op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b   rs (multiplicand / dividend), rt (multiplier / divisor)
//   mthi, mtlo     write wdata into HI / LO (idle only)
//   wdata          MTHI/MTLO data
//   busy           operation in progress (hazard logic stalls MFHI/MFLO)
//   done           one-cycle pulse, HI/LO hold the new result
//   div_by_zero    valid with done, divisor was zero
//   hi, lo         architectural HI / LO registers
// -----------------------------------------------------------------------------
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT       state, stateNext;
  logic [4:0]  count;
  logic [31:0] operand;   // multiplicand (mult) or divisor (div)
  logic [31:0] accHi;     // product high half / partial remainder
  logic [31:0] accLo;     // multiplier shifting out / dividend -> quotient
  logic        mulNeg;
  logic [31:0] hiReg, loReg;
  logic        doneReg, dbzReg;

  logic        launch;
  logic [31:0] absA, absB;
  logic [32:0] mulSum;
  logic [63:0] prodFix;

`ifdef MULT_DIV_UNIT_DIVIDER_EN
  logic        isDiv;
  logic        quoNeg, remNeg;
  logic [31:0] rawA;      // unmodified dividend, returned in HI on divide by zero
  logic [32:0] divShift, divDiff;
  logic [31:0] quoFix, remFix;

  assign launch = start;
`else
  // Without the divider a DIV/DIVU request is acknowledged but never runs.
  assign launch = start & ~op[1];
`endif

  // Magnitudes are only taken for the signed ops (op[0]=0).
  assign absA = (~op[0] && src_a[31]) ? -src_a : src_a;
  assign absB = (~op[0] && src_b[31]) ? -src_b : src_b;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state <= stateNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path leaves stateNext unassigned (no latch).
    stateNext = state;
    case (state)
      IDLE:    if (launch) stateNext = RUN;
      RUN:     if (count == 5'd31) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-iteration arithmetic and final sign correction
  // ---------------------------------------------------------------------------
  always_comb begin
    // Shift-add: conditionally add the multiplicand to the upper half, then
    // the 33-bit sum and the multiplier shift right together.
    mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : 33'd0);
    prodFix = mulNeg ? -{accHi, accLo} : {accHi, accLo};
`ifdef MULT_DIV_UNIT_DIVIDER_EN
    // Restoring step: bring in the next dividend bit and try to subtract.
    // A clear borrow bit (divDiff[32]) means the trial subtraction fits.
    divShift = {accHi, accLo[31]};
    divDiff  = divShift - {1'b0, operand};
    quoFix   = quoNeg ? -accLo : accLo;
    remFix   = remNeg ? -accHi : accHi;
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath and HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every datapath register is reset, not just the architectural
      // ones; the set is small and it keeps post-reset behaviour deterministic.
      count   <= '0;
      operand <= '0;
      accHi   <= '0;
      accLo   <= '0;
      mulNeg  <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDER_EN
      isDiv   <= 1'b0;
      quoNeg  <= 1'b0;
      remNeg  <= 1'b0;
      rawA    <= '0;
`endif
    end else begin
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Any MTHI/MTLO in the same cycle as a start is dropped.
            if (launch) begin
              count  <= '0;
              accHi  <= '0;
              mulNeg <= (op == 2'b00) && (src_a[31] ^ src_b[31]);
`ifdef MULT_DIV_UNIT_DIVIDER_EN
              isDiv   <= op[1];
              quoNeg  <= (op == 2'b10) && (src_a[31] ^ src_b[31]);
              remNeg  <= (op == 2'b10) && src_a[31];
              rawA    <= src_a;
              operand <= op[1] ? absB : absA;
              accLo   <= op[1] ? absA : absB;
`else
              operand <= absA;
              accLo   <= absB;
`endif
            end else begin
              doneReg <= 1'b1;
            end
          end else begin
            if (mthi) hiReg <= wdata;
            if (mtlo) loReg <= wdata;
          end
        end

        RUN: begin
          count <= count + 5'd1;
`ifdef MULT_DIV_UNIT_DIVIDER_EN
          if (isDiv) begin
            accHi <= divDiff[32] ? divShift[31:0] : divDiff[31:0];
            accLo <= {accLo[30:0], ~divDiff[32]};
          end else begin
            accHi <= mulSum[32:1];
            accLo <= {mulSum[0], accLo[31:1]};
          end
`else
          accHi <= mulSum[32:1];
          accLo <= {mulSum[0], accLo[31:1]};
`endif
        end

        FIX: begin
          doneReg <= 1'b1;
`ifdef MULT_DIV_UNIT_DIVIDER_EN
          if (isDiv) begin
            if (operand == '0) begin
              hiReg  <= rawA;
              loReg  <= '1;
              dbzReg <= 1'b1;
            end else begin
              hiReg <= remFix;
              loReg <= quoFix;
            end
          end else begin
            hiReg <= prodFix[63:32];
            loReg <= prodFix[31:0];
          end
`else
          hiReg <= prodFix[63:32];
          loReg <= prodFix[31:0];
`endif
        end

        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = doneReg;
  assign div_by_zero = dbzReg;
  assign hi          = hiReg;
  assign lo          = loReg;

endmodule
